// File: rtl/ofm_in_fsm_pkg.sv
// Shared definitions for the 10GbE TX ingress framer and the MAC output stage:
// FSM encoding, descriptor layout, TXC flag value and FIFO widths.
package ofm_in_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_DATA = 2'd2,
    S_EOF  = 2'd3
  } state_t;

  localparam int DATA_FIFO_W = 73;
  localparam int CTRL_FIFO_W = 64;

  localparam logic [3:0] TXC_FLAG = 4'hA;

  localparam int DESC_CNT_LSB       = 0;
  localparam int DESC_CSUM_BIT      = 16;
  localparam int DESC_OVERSIZE_BIT  = 17;
  localparam int DESC_BAD_FLAG_BIT  = 18;
  localparam int DESC_CS_BEGIN_LSB  = 32;
  localparam int DESC_CS_INSERT_LSB = 48;

  function automatic logic [CTRL_FIFO_W-1:0] make_desc(
    input logic [15:0] byte_cnt,
    input logic        csum_en,
    input logic        oversize,
    input logic        bad_flag,
    input logic [15:0] cs_begin,
    input logic [15:0] cs_insert
  );
    logic [CTRL_FIFO_W-1:0] d;
    d = '0;
    d[DESC_CNT_LSB +: 16]       = byte_cnt;
    d[DESC_CSUM_BIT]            = csum_en;
    d[DESC_OVERSIZE_BIT]        = oversize;
    d[DESC_BAD_FLAG_BIT]        = bad_flag;
    d[DESC_CS_BEGIN_LSB +: 16]  = cs_begin;
    d[DESC_CS_INSERT_LSB +: 16] = cs_insert;
    return d;
  endfunction

endpackage

// File: rtl/ofm_in_fsm_if.sv
// TXC/TXD AXI-Stream sinks plus the data/ctrl FIFO write ports of the TX framer.
// The framer uses the slave view; the DMA/FIFO side (or a bench) uses master.
interface ofm_in_fsm_if;
  import ofm_in_fsm_pkg::*;

  logic [31:0]            s_axis_txc_tdata;
  logic                   s_axis_txc_tvalid;
  logic                   s_axis_txc_tlast;
  logic                   s_axis_txc_tready;

  logic [63:0]            s_axis_txd_tdata;
  logic [7:0]             s_axis_txd_tkeep;
  logic                   s_axis_txd_tvalid;
  logic                   s_axis_txd_tlast;
  logic                   s_axis_txd_tready;

  logic [DATA_FIFO_W-1:0] data_fifo_wdata;
  logic                   data_fifo_wren;
  logic                   data_fifo_full;
  logic [CTRL_FIFO_W-1:0] ctrl_fifo_wdata;
  logic                   ctrl_fifo_wren;
  logic                   ctrl_fifo_full;

  modport slave (
    input  s_axis_txc_tdata, s_axis_txc_tvalid, s_axis_txc_tlast,
    output s_axis_txc_tready,
    input  s_axis_txd_tdata, s_axis_txd_tkeep, s_axis_txd_tvalid, s_axis_txd_tlast,
    output s_axis_txd_tready,
    output data_fifo_wdata, data_fifo_wren,
    input  data_fifo_full,
    output ctrl_fifo_wdata, ctrl_fifo_wren,
    input  ctrl_fifo_full
  );

  modport master (
    output s_axis_txc_tdata, s_axis_txc_tvalid, s_axis_txc_tlast,
    input  s_axis_txc_tready,
    output s_axis_txd_tdata, s_axis_txd_tkeep, s_axis_txd_tvalid, s_axis_txd_tlast,
    input  s_axis_txd_tready,
    input  data_fifo_wdata, data_fifo_wren,
    output data_fifo_full,
    input  ctrl_fifo_wdata, ctrl_fifo_wren,
    output ctrl_fifo_full
  );

endinterface

// File: rtl/ofm_keep_cnt.sv
// Byte count of one TXD beat: population count of the 8-bit tkeep.
module ofm_keep_cnt (
  input  logic [7:0] tkeep,
  output logic [3:0] count
);

  always_comb begin
    // NOTE: default first so every path assigns count and no latch is inferred;
    // blocking '=' is correct here because the loop accumulates combinationally.
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, tkeep[i]};
    end
  end

endmodule

// File: rtl/ofm_in_fsm.sv
// TX ingress framer: reserves a ctrl FIFO slot, captures TXC fields, streams TXD
// beats into the data FIFO and writes one 64b descriptor per frame.
module ofm_in_fsm
  import ofm_in_fsm_pkg::*;
#(
  parameter int C_MAX_LEN   = 9600,
  parameter int C_TXC_WORDS = 6
) (
  input  logic         tx_clk,
  input  logic         tx_reset,
  ofm_in_fsm_if.slave  bus
);

  localparam logic [15:0] MAX_LEN = 16'(C_MAX_LEN);
  localparam logic [2:0]  IDX_SAT = 3'(C_TXC_WORDS);

  state_t                 state;
  logic                   txc_tready_q;
  logic                   txd_en_q;
  logic                   ctrl_wren_q;
  logic [CTRL_FIFO_W-1:0] desc_q;
  logic [2:0]             word_idx;
  logic [15:0]            byte_cnt;
  logic                   csum_en;
  logic                   bad_flag;
  logic [15:0]            cs_begin;
  logic [15:0]            cs_insert;

  logic [3:0]             beat_bytes;
  logic [16:0]            cnt_sum;
  logic [15:0]            cnt_next;
  logic                   txc_acc;
  logic                   txd_acc;

  ofm_keep_cnt u_keep_cnt (
    .tkeep (bus.s_axis_txd_tkeep),
    .count (beat_bytes)
  );

  assign bus.s_axis_txc_tready = txc_tready_q;
  assign bus.s_axis_txd_tready = txd_en_q & ~bus.data_fifo_full;
  assign txc_acc = bus.s_axis_txc_tvalid & txc_tready_q;
  assign txd_acc = bus.s_axis_txd_tvalid & bus.s_axis_txd_tready;

  assign bus.data_fifo_wdata = {bus.s_axis_txd_tlast, bus.s_axis_txd_tkeep, bus.s_axis_txd_tdata};
  assign bus.data_fifo_wren  = txd_acc;
  assign bus.ctrl_fifo_wdata = desc_q;
  assign bus.ctrl_fifo_wren  = ctrl_wren_q;

  // Running count saturates so jumbo overruns still read as oversize.
  assign cnt_sum  = {1'b0, byte_cnt} + {13'd0, beat_bytes};
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge tx_clk) begin
    if (tx_reset) begin
      state        <= S_IDLE;
      txc_tready_q <= 1'b0;
      txd_en_q     <= 1'b0;
      ctrl_wren_q  <= 1'b0;
      desc_q       <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      csum_en      <= 1'b0;
      bad_flag     <= 1'b0;
      cs_begin     <= '0;
      cs_insert    <= '0;
    end else begin
      ctrl_wren_q <= 1'b0;
      case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          // Only this block writes the ctrl FIFO, so a free slot now is ours at S_EOF.
          if (!bus.ctrl_fifo_full) begin
            state        <= S_CTRL;
            txc_tready_q <= 1'b1;
            word_idx     <= '0;
            csum_en      <= 1'b0;
            bad_flag     <= 1'b0;
            cs_begin     <= '0;
            cs_insert    <= '0;
          end
        end
        S_CTRL: begin
          if (txc_acc) begin
            if (word_idx == 3'd0) bad_flag <= (bus.s_axis_txc_tdata[31:28] != TXC_FLAG);
            if (word_idx == 3'd1) csum_en  <= bus.s_axis_txc_tdata[0];
            if (word_idx == 3'd2) begin
              cs_begin  <= bus.s_axis_txc_tdata[31:16];
              cs_insert <= bus.s_axis_txc_tdata[15:0];
            end
            if (word_idx < IDX_SAT) word_idx <= word_idx + 3'd1;
            if (bus.s_axis_txc_tlast) begin
              state        <= S_DATA;
              txc_tready_q <= 1'b0;
              txd_en_q     <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (txd_acc) begin
            byte_cnt <= cnt_next;
            if (bus.s_axis_txd_tlast) begin
              state       <= S_EOF;
              txd_en_q    <= 1'b0;
              ctrl_wren_q <= 1'b1;
              desc_q      <= make_desc(cnt_next, csum_en, (cnt_next > MAX_LEN),
                                       bad_flag, cs_begin, cs_insert);
            end
          end
        end
        S_EOF:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_in_fsm.sv
// Self-checking bench for ofm_in_fsm: directed frames plus randomized traffic with
// FIFO back-pressure, checked against a frame-level descriptor/data model.
module tb_ofm_in_fsm;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic tx_clk;
  logic tx_reset;

  ofm_in_fsm_if bus ();

  ofm_in_fsm #(.C_MAX_LEN(9600), .C_TXC_WORDS(6)) dut (
    .tx_clk   (tx_clk),
    .tx_reset (tx_reset),
    .bus      (bus)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int          passed = 0;
  int          total  = 0;
  int          proto_err = 0;
  bit          abort_drv = 1'b0;
  bit          gaps_en = 1'b0;
  logic [31:0] txc_q[$];
  beat_t       txd_q[$];
  logic [72:0] mon_data[$];
  logic [63:0] mon_desc[$];
  logic [63:0] last_desc;
  logic [72:0] last_word;

  // Write-port monitor: a strobe seen at the falling edge commits at the next rising edge.
  always @(negedge tx_clk) begin
    if (!tx_reset) begin
      if (bus.data_fifo_wren) mon_data.push_back(bus.data_fifo_wdata);
      if (bus.ctrl_fifo_wren) mon_desc.push_back(bus.ctrl_fifo_wdata);
      if (bus.data_fifo_wren && (bus.data_fifo_full || !bus.s_axis_txd_tvalid)) proto_err++;
      if (bus.s_axis_txc_tready && bus.s_axis_txd_tready) proto_err++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] contig(input int k);
    logic [15:0] t;
    t = (16'd1 << k) - 16'd1;
    return t[7:0];
  endfunction

  // Frame-level model: descriptor from the TXC words and the sum of enabled bytes.
  function automatic logic [63:0] model_desc();
    longint      sum = 0;
    logic [31:0] w0, w1, w2;
    logic [15:0] cnt;
    logic        bad, csum, over;
    foreach (txd_q[i]) sum += $countones(txd_q[i].keep);
    cnt  = (sum > 65535) ? 16'hFFFF : 16'(sum);
    over = (sum > 9600);
    w0   = txc_q[0];
    w1   = (txc_q.size() > 1) ? txc_q[1] : 32'd0;
    w2   = (txc_q.size() > 2) ? txc_q[2] : 32'd0;
    bad  = (w0[31:28] != 4'hA);
    csum = w1[0];
    return {w2[15:0], w2[31:16], 13'd0, bad, over, csum, cnt};
  endfunction

  task automatic build_txd(input int nbeats, input logic [7:0] last_keep, input bit rand_keep);
    beat_t b;
    txd_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == nbeats - 1);
      if (b.last) b.keep = last_keep;
      else if (rand_keep && $urandom_range(0, 3) == 0) b.keep = contig($urandom_range(1, 8));
      else b.keep = 8'hFF;
      txd_q.push_back(b);
    end
  endtask

  task automatic wait_ready(input bit is_txd);
    int n   = 0;
    bit acc = 1'b0;
    while (!acc && !abort_drv) begin
      @(negedge tx_clk);
      acc = is_txd ? bus.s_axis_txd_tready : bus.s_axis_txc_tready;
      @(posedge tx_clk); #1;
      n++;
      if (!acc && n >= 400) begin
        total++;
        $display("FAIL handshake_%s: tready low for %0d cycles, required within 400",
                 is_txd ? "txd" : "txc", n);
        abort_drv = 1'b1;
      end
    end
  endtask

  task automatic drive_txc();
    foreach (txc_q[i]) begin
      if (abort_drv) break;
      if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge tx_clk); #1; end
      bus.s_axis_txc_tdata  = txc_q[i];
      bus.s_axis_txc_tlast  = (i == txc_q.size() - 1);
      bus.s_axis_txc_tvalid = 1'b1;
      wait_ready(1'b0);
      bus.s_axis_txc_tvalid = 1'b0;
      bus.s_axis_txc_tlast  = 1'b0;
    end
  endtask

  // Runs concurrently with drive_txc, so TXD valid is often presented during S_CTRL.
  task automatic drive_txd();
    foreach (txd_q[i]) begin
      if (abort_drv) break;
      if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge tx_clk); #1; end
      bus.s_axis_txd_tdata  = txd_q[i].data;
      bus.s_axis_txd_tkeep  = txd_q[i].keep;
      bus.s_axis_txd_tlast  = txd_q[i].last;
      bus.s_axis_txd_tvalid = 1'b1;
      wait_ready(1'b1);
      bus.s_axis_txd_tvalid = 1'b0;
      bus.s_axis_txd_tlast  = 1'b0;
    end
  endtask

  task automatic run_frame(input string name);
    int          db = mon_data.size();
    int          cb = mon_desc.size();
    int          n  = 0;
    int          bad = 0;
    int          first = -1;
    logic [63:0] exp_desc;
    logic [72:0] exp_word;
    exp_desc = model_desc();
    fork
      drive_txc();
      drive_txd();
    join
    while (mon_desc.size() == cb && n < 50) begin @(posedge tx_clk); #1; n++; end
    repeat (2) begin @(posedge tx_clk); #1; end
    total++;
    if (mon_desc.size() !== cb + 1)
      $display("FAIL %s desc_writes: got %0d, required 1", name, mon_desc.size() - cb);
    else passed++;
    last_desc = (mon_desc.size() > cb) ? mon_desc[cb] : 64'hx;
    total++;
    if (last_desc !== exp_desc)
      $display("FAIL %s desc: got %h, required %h", name, last_desc, exp_desc);
    else passed++;
    total++;
    if (mon_data.size() - db !== txd_q.size())
      $display("FAIL %s data_writes: got %0d, required %0d", name, mon_data.size() - db, txd_q.size());
    else passed++;
    foreach (txd_q[i]) begin
      exp_word = {txd_q[i].last, txd_q[i].keep, txd_q[i].data};
      if (db + i >= mon_data.size() || mon_data[db + i] !== exp_word) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    last_word = (mon_data.size() > db) ? mon_data[mon_data.size() - 1] : 73'hx;
    total++;
    if (bad !== 0) begin
      exp_word = {txd_q[first].last, txd_q[first].keep, txd_q[first].data};
      $display("FAIL %s data_words: %0d wrong, first beat %0d got %h, required %h", name, bad, first,
               (db + first < mon_data.size()) ? mon_data[db + first] : 73'hx, exp_word);
    end else passed++;
  endtask

  task automatic std_txc(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    txc_q.delete();
    txc_q.push_back(w0);
    txc_q.push_back(w1);
    txc_q.push_back(w2);
    repeat (3) txc_q.push_back($urandom);
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    tx_reset = 1'b1;
    repeat (3) begin @(posedge tx_clk); #1; end
    outs = {bus.s_axis_txc_tready, bus.s_axis_txd_tready, bus.data_fifo_wren,
            bus.ctrl_fifo_wren, bus.ctrl_fifo_wdata, 2'b00};
    total++;
    if (outs !== 70'd0) $display("FAIL reset_outputs: got %h, required 0", outs);
    else passed++;
    tx_reset = 1'b0;
    @(posedge tx_clk); #1;
    total++;
    if (bus.s_axis_txc_tready !== 1'b1)
      $display("FAIL reset_exit_txc_tready: got %b, required 1", bus.s_axis_txc_tready);
    else passed++;
  endtask

  task automatic test_basic_64b();
    std_txc(32'hA000_0000, 32'h0000_0001, 32'h0022_0032);
    build_txd(8, 8'hFF, 1'b0);
    run_frame("basic_64b");
    total++;
    if (last_desc !== 64'h0032_0022_0001_0040)
      $display("FAIL basic_64b_literal: got %h, required 0032002200010040", last_desc);
    else passed++;
  endtask

  task automatic test_short_last();
    std_txc(32'hA123_4567, 32'h0, 32'h0);
    build_txd(8, 8'h1F, 1'b0);
    run_frame("short_61b");
    total++;
    if (last_desc[15:0] !== 16'h003D || last_word[72] !== 1'b1 || last_word[71:64] !== 8'h1F)
      $display("FAIL short_61b_fields: got cnt %h last %b keep %h, required 003d 1 1f",
               last_desc[15:0], last_word[72], last_word[71:64]);
    else passed++;
  endtask

  task automatic test_data_stall();
    int db  = mon_data.size();
    int bad = 0;
    int n   = 0;
    std_txc(32'hA000_0000, 32'h1, 32'h0022_0032);
    build_txd(8, 8'hFF, 1'b0);
    fork
      run_frame("data_stall");
      begin
        while (mon_data.size() - db < 3 && n < 200) begin @(posedge tx_clk); #1; n++; end
        bus.data_fifo_full = 1'b1;
        repeat (5) begin
          @(negedge tx_clk);
          if (bus.s_axis_txd_tready !== 1'b0 || bus.data_fifo_wren !== 1'b0) bad++;
        end
        @(posedge tx_clk); #1;
        bus.data_fifo_full = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL data_stall_hold: %0d cycles with tready/wren high, required 0", bad);
        else passed++;
      end
    join
    total++;
    if (last_desc[15:0] !== 16'd64)
      $display("FAIL data_stall_count: got %0d, required 64", last_desc[15:0]);
    else passed++;
  endtask

  task automatic test_ctrl_full();
    int bad = 0;
    bus.ctrl_fifo_full = 1'b1;
    @(posedge tx_clk); #1;
    tx_reset = 1'b1;
    @(posedge tx_clk); #1;
    tx_reset = 1'b0;
    std_txc(32'hA000_0000, 32'h0, 32'h1111_2222);
    build_txd(3, 8'h07, 1'b0);
    fork
      run_frame("ctrl_full");
      begin
        repeat (6) begin
          @(negedge tx_clk);
          if (bus.s_axis_txc_tready !== 1'b0) bad++;
        end
        @(posedge tx_clk); #1;
        bus.ctrl_fifo_full = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL ctrl_full_block: %0d cycles with txc_tready high, required 0", bad);
        else passed++;
      end
    join
  endtask

  task automatic test_flags();
    txc_q.delete();
    txc_q.push_back(32'h5000_0000);
    txc_q.push_back(32'h0000_0001);
    build_txd(2, 8'hFF, 1'b0);
    run_frame("early_tlast_bad_flag");
    total++;
    if (last_desc !== 64'h0000_0000_0005_0010)
      $display("FAIL early_tlast_literal: got %h, required 0000000000050010", last_desc);
    else passed++;
  endtask

  task automatic test_oversize();
    std_txc(32'hA000_0000, 32'h0, 32'h0);
    build_txd(1201, 8'h01, 1'b0);
    run_frame("len_9601");
    total++;
    if (last_desc[17] !== 1'b1 || last_desc[15:0] !== 16'h2581)
      $display("FAIL len_9601_flag: got over %b cnt %h, required 1 2581", last_desc[17], last_desc[15:0]);
    else passed++;
    build_txd(1200, 8'hFF, 1'b0);
    run_frame("len_9600");
    total++;
    if (last_desc[17] !== 1'b0 || last_desc[15:0] !== 16'h2580)
      $display("FAIL len_9600_flag: got over %b cnt %h, required 0 2580", last_desc[17], last_desc[15:0]);
    else passed++;
    build_txd(8192, 8'hFF, 1'b0);
    run_frame("len_saturate");
    total++;
    if (last_desc[17:0] !== 18'h2FFFF)
      $display("FAIL len_saturate_cnt: got %h, required 2ffff", last_desc[17:0]);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int          db = mon_data.size();
    int          cb = mon_desc.size();
    int          n  = 0;
    logic [67:0] outs;
    std_txc(32'hA000_0000, 32'h1, 32'h0022_0032);
    build_txd(8, 8'hFF, 1'b0);
    fork
      begin
        fork
          drive_txc();
          drive_txd();
        join
      end
      begin
        while (mon_data.size() - db < 2 && n < 200) begin @(posedge tx_clk); #1; n++; end
        tx_reset = 1'b1;
        @(posedge tx_clk); #1;
        outs = {bus.s_axis_txc_tready, bus.s_axis_txd_tready, bus.data_fifo_wren,
                bus.ctrl_fifo_wren, bus.ctrl_fifo_wdata};
        total++;
        if (outs !== 68'd0) $display("FAIL reset_mid_outputs: got %h, required 0", outs);
        else passed++;
        abort_drv = 1'b1;
      end
    join
    bus.s_axis_txc_tvalid = 1'b0;
    bus.s_axis_txd_tvalid = 1'b0;
    @(posedge tx_clk); #1;
    tx_reset  = 1'b0;
    abort_drv = 1'b0;
    repeat (3) begin @(posedge tx_clk); #1; end
    total++;
    if (mon_desc.size() !== cb)
      $display("FAIL reset_mid_no_desc: got %0d descriptors, required 0", mon_desc.size() - cb);
    else passed++;
    std_txc(32'hA000_0000, 32'h0, 32'h0044_0055);
    build_txd(5, 8'h3F, 1'b0);
    run_frame("after_reset");
  endtask

  task automatic test_random();
    bit rand_on = 1'b1;
    gaps_en = 1'b1;
    fork
      begin
        for (int f = 0; f < 25; f++) begin
          int nw = $urandom_range(1, 8);
          txc_q.delete();
          for (int w = 0; w < nw; w++) begin
            logic [31:0] v = $urandom;
            if (w == 0 && $urandom_range(0, 1) == 1) v[31:28] = 4'hA;
            txc_q.push_back(v);
          end
          build_txd($urandom_range(1, 12), contig($urandom_range(1, 8)), 1'b1);
          run_frame($sformatf("random_%0d", f));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge tx_clk); #1;
          bus.data_fifo_full = ($urandom_range(0, 3) == 0);
          bus.ctrl_fifo_full = ($urandom_range(0, 2) == 0);
        end
        bus.data_fifo_full = 1'b0;
        bus.ctrl_fifo_full = 1'b0;
      end
    join
    gaps_en = 1'b0;
  endtask

  initial begin
    tx_reset              = 1'b1;
    bus.s_axis_txc_tdata  = '0;
    bus.s_axis_txc_tvalid = 1'b0;
    bus.s_axis_txc_tlast  = 1'b0;
    bus.s_axis_txd_tdata  = '0;
    bus.s_axis_txd_tkeep  = '0;
    bus.s_axis_txd_tvalid = 1'b0;
    bus.s_axis_txd_tlast  = 1'b0;
    bus.data_fifo_full    = 1'b0;
    bus.ctrl_fifo_full    = 1'b0;

    test_reset();
    test_basic_64b();
    test_short_last();
    test_data_stall();
    test_ctrl_full();
    test_flags();
    test_oversize();
    test_reset_mid_frame();
    test_random();

    total++;
    if (proto_err !== 0) $display("FAIL protocol: got %0d violations, required 0", proto_err);
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
